// File: rtl/shift_cmd_pipe.sv
// Command FIFO feeding an external barrel shifter, with a registered result stage.
// Optional macro SHIFT_ZERO_FLAG_EN adds out_zero, a registered (result == 0) flag.
module shift_cmd_pipe #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [4:0]               in_b,
    input  logic [1:0]               in_aluc,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [31:0]              sh_a,
    output logic [4:0]               sh_b,
    output logic [1:0]               sh_aluc,
    input  logic [31:0]              sh_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_c,
    output logic [TAG_W-1:0]         out_tag,
`ifdef SHIFT_ZERO_FLAG_EN
    output logic                     out_zero,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0]      a;
        logic [4:0]       b;
        logic [1:0]       aluc;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    cmd_t              mem_q [DEPTH];
    cmd_t              wr_cmd;
    cmd_t              head;

    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_c_q, out_c_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_zero_q, out_zero_d;

    logic              push;
    logic              pop;
    logic              not_empty;

    // Readiness depends only on occupancy, so a full FIFO refuses a push even
    // when the same edge frees a slot.
    always_comb begin
        not_empty = (count_q != '0);
        in_ready  = (count_q < CW'(DEPTH));
        push      = in_valid && in_ready;
        pop       = not_empty && (!out_valid_q || out_ready);
        head      = mem_q[rptr_q];

        wr_cmd.a    = in_a;
        wr_cmd.b    = in_b;
        wr_cmd.aluc = in_aluc;
        wr_cmd.tag  = in_tag;
    end

    always_comb begin
        sh_a    = '0;
        sh_b    = '0;
        sh_aluc = '0;
        if (not_empty) begin
            sh_a    = head.a;
            sh_b    = head.b;
            sh_aluc = head.aluc;
        end
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        out_tag_d   = out_tag_q;
        out_zero_d  = out_zero_q;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end

        if (pop) begin
            rptr_d      = rptr_q + AW'(1);
            out_valid_d = 1'b1;
            out_c_d     = sh_c;
            out_tag_d   = head.tag;
            out_zero_d  = (sh_c == '0);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_tag_q   <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_tag_q   <= out_tag_d;
            out_zero_q  <= out_zero_d;
        end
    end

    // Storage needs no reset: the sh_* outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_cmd;
        end
    end

    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign out_tag   = out_tag_q;
    assign count     = count_q;

`ifdef SHIFT_ZERO_FLAG_EN
    assign out_zero  = out_zero_q;
`else
    logic unused_zero;
    assign unused_zero = out_zero_q;
`endif

endmodule

// File: tb/tb_shift_cmd_pipe.sv
// Self-checking bench for shift_cmd_pipe: vector table, corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_shift_cmd_pipe;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_a;
    logic [4:0]        in_b;
    logic [1:0]        in_aluc;
    logic [TAG_W-1:0]  in_tag;
    logic [31:0]       sh_a;
    logic [4:0]        sh_b;
    logic [1:0]        sh_aluc;
    logic [31:0]       sh_c;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_c;
    logic [TAG_W-1:0]  out_tag;
    logic [CW-1:0]     count;
`ifdef SHIFT_ZERO_FLAG_EN
    logic              out_zero;
`endif

    always #5 clk = ~clk;

    shift_cmd_pipe #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_aluc   (in_aluc),
        .in_tag    (in_tag),
        .sh_a      (sh_a),
        .sh_b      (sh_b),
        .sh_aluc   (sh_aluc),
        .sh_c      (sh_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_tag   (out_tag),
`ifdef SHIFT_ZERO_FLAG_EN
        .out_zero  (out_zero),
`endif
        .count     (count)
    );

    // External barrel shifter
    always_comb begin
        case (sh_aluc)
            2'b00:   sh_c = $unsigned($signed(sh_a) >>> sh_b);
            2'b10:   sh_c = sh_a >> sh_b;
            default: sh_c = sh_a << sh_b;
        endcase
    end

    typedef struct {
        logic [31:0]      a;
        logic [4:0]       b;
        logic [1:0]       aluc;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  aluc;
        logic [31:0] exp;
    } vec_t;

    cmd_t              mq[$];
    bit                m_valid;
    logic [31:0]       m_c;
    logic [TAG_W-1:0]  m_tag;
    bit                m_zero;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                              input logic [1:0] aluc);
        logic [63:0] p;
        logic [63:0] r;
        p = 64'd1;
        for (int i = 0; i < int'(b); i++) p = p * 64'd2;
        case (aluc)
            2'b00:   r = {{32{a[31]}}, a} / p;
            2'b10:   r = {32'd0, a} / p;
            default: r = {32'd0, a} * p;
        endcase
        return r[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   push;
        bit   pop;
        cmd_t h;
        cmd_t n;
        if (rst) begin
            mq.delete();
            m_valid = 0;
            m_c     = '0;
            m_tag   = '0;
            m_zero  = 0;
            return;
        end
        push = in_valid && (mq.size() < DEPTH);
        pop  = (mq.size() != 0) && (!m_valid || out_ready);
        if (pop) begin
            h       = mq.pop_front();
            m_c     = ref_shift(h.a, h.b, h.aluc);
            m_tag   = h.tag;
            m_zero  = (m_c == 0);
            m_valid = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (push) begin
            n.a = in_a; n.b = in_b; n.aluc = in_aluc; n.tag = in_tag;
            mq.push_back(n);
        end
    endtask

    task automatic check_model();
        chk("count",     32'(count),     32'(mq.size()));
        chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_c",     out_c,          m_c);
        chk("out_tag",   32'(out_tag),   32'(m_tag));
`ifdef SHIFT_ZERO_FLAG_EN
        chk("out_zero",  32'(out_zero),  32'(m_zero));
`endif
        if (mq.size() != 0) begin
            chk("sh_a",    sh_a,          mq[0].a);
            chk("sh_b",    32'(sh_b),     32'(mq[0].b));
            chk("sh_aluc", 32'(sh_aluc),  32'(mq[0].aluc));
        end else begin
            chk("sh_idle", {sh_a[26:0], sh_b}, 32'd0);
            chk("sh_idle_aluc", 32'(sh_aluc), 32'd0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic [31:0] a, input logic [4:0] b, input logic [1:0] aluc,
                         input logic [TAG_W-1:0] tag);
        in_a = a; in_b = b; in_aluc = aluc; in_tag = tag;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        int   j;
        bit   acc;

        tbl[0] = '{32'h80000000, 5'd4,  2'b00, 32'hF8000000};
        tbl[1] = '{32'h00000001, 5'd31, 2'b01, 32'h80000000};
        tbl[2] = '{32'h80000000, 5'd31, 2'b10, 32'h00000001};
        tbl[3] = '{32'h0000F0F0, 5'd4,  2'b11, 32'h000F0F00};
        tbl[4] = '{32'h7FFFFFFF, 5'd31, 2'b00, 32'h00000000};
        tbl[5] = '{32'hFFFFFFFF, 5'd0,  2'b00, 32'hFFFFFFFF};
        tbl[6] = '{32'hFFFF0000, 5'd16, 2'b10, 32'h0000FFFF};
        tbl[7] = '{32'h80000000, 5'd31, 2'b00, 32'hFFFFFFFF};
        tbl[8] = '{32'h12345678, 5'd8,  2'b11, 32'h34567800};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive('0, '0, '0, '0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_c",     out_c,          32'd0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Table vectors, back to back: each result appears one edge after acceptance.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            drive(tbl[i].a, tbl[i].b, tbl[i].aluc, TAG_W'(i));
            tick();
            if (i == 0) begin
                chk("no_bypass", 32'(out_valid), 32'd0);
            end else begin
                chk("vec_valid", 32'(out_valid), 32'd1);
                chk("vec_c",     out_c,          tbl[i-1].exp);
                chk("vec_tag",   32'(out_tag),   32'(i-1));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("vec_last_c", out_c, tbl[8].exp);
        tick();
        chk("vec_drained", 32'(out_valid), 32'd0);

        // Backpressure: six offered, five accepted.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        j = 0;
        repeat (6) begin
            drive(32'h00001111 * (j + 1), 5'(j), 2'b01, TAG_W'(j + 1));
            acc = (mq.size() < DEPTH);
            tick();
            if (acc) j++;
        end
        chk("bp_accepted", 32'(j),         32'd5);
        chk("bp_count",    32'(count),     32'd4);
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_held_tag", 32'(out_tag),   32'd1);
        repeat (3) tick();
        chk("bp_stable_c",   out_c,        32'h00001111);
        chk("bp_stable_tag", 32'(out_tag), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("bp_order", 32'(out_tag), 32'(k));
        end
        chk("bp_count_end", 32'(count), 32'd0);
        tick();
        chk("bp_done", 32'(out_valid), 32'd0);

        // Full FIFO with a simultaneous pop: the push waits one cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 6; k <= 10; k++) begin
            drive(32'(k), 5'd1, 2'b01, TAG_W'(k));
            tick();
        end
        chk("full_count", 32'(count), 32'd4);
        drive(32'h0000000B, 5'd2, 2'b01, TAG_W'(11));
        out_ready = 1'b1;
        tick();
        chk("full_pop_count", 32'(count), 32'd3);
        tick();
        chk("full_push_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        repeat (3) tick();
        chk("full_last_tag", 32'(out_tag), 32'd11);
        chk("full_last_c",   out_c,        32'h0000002C);
        tick();

        // Reset with work in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 12; k <= 15; k++) begin
            drive(32'h00010000 + 32'(k), 5'd0, 2'b10, TAG_W'(k));
            tick();
        end
        chk("mid_count", 32'(count),     32'd3);
        chk("mid_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(count),     32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        out_ready = 1'b1;
        repeat (6) begin
            tick();
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end

`ifdef SHIFT_ZERO_FLAG_EN
        in_valid = 1'b1;
        drive(32'h00000001, 5'd1, 2'b10, TAG_W'(1));
        tick();
        drive(32'h00000003, 5'd1, 2'b10, TAG_W'(2));
        tick();
        in_valid = 1'b0;
        chk("zf_c0", out_c, 32'd0);
        chk("zf_z1", 32'(out_zero), 32'd1);
        tick();
        chk("zf_c1", out_c, 32'd1);
        chk("zf_z0", 32'(out_zero), 32'd0);
        tick();
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                  TAG_W'($urandom_range(0, (1 << TAG_W) - 1)));
            if ($urandom_range(0, 7) == 0) in_a = '0;
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_cmd_pipe.md
SHIFT_CMD_PIPE -- requirements
Module: shift_cmd_pipe

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of 2, at least 2).
REQ-002 Parameter TAG_W, default 4, width of the user tag carried with each command.
REQ-003 clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  producer offers a command.
REQ-006 in_ready  output  1  the block can accept a command.
REQ-007 in_a  input  32  operand to shift.
REQ-008 in_b  input  5  shift amount.
REQ-009 in_aluc  input  2  shift op: 00 sra, 01 sll, 10 srl, 11 sll.
REQ-010 in_tag  input  TAG_W  user tag, returned unchanged with the result.
REQ-011 sh_a / sh_b / sh_aluc  output  32/5/2  drive the external barrel shifter.
REQ-012 sh_c  input  32  combinational result returned by the external barrel shifter.
REQ-013 out_valid  output  1  the result register holds a result.
REQ-014 out_ready  input  1  the consumer takes the result.
REQ-015 out_c / out_tag  output  32/TAG_W  shifted result and its tag.
REQ-016 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 A command is accepted on a rising edge where in_valid && in_ready; the accepted command is written at the FIFO tail.
REQ-018 in_ready SHALL equal (count < DEPTH); a push while full is ignored, even if a pop occurs in the same cycle.
REQ-019 sh_a, sh_b and sh_aluc SHALL be driven combinationally from the FIFO head entry; they SHALL be 0 when the FIFO is empty.
REQ-020 A pop occurs on a rising edge where count != 0 && (!out_valid || out_ready).
REQ-021 On a pop, out_c <= sh_c, out_tag <= head tag, out_valid <= 1, and the read pointer advances.
REQ-022 When out_valid && out_ready and no pop occurs on that edge, out_valid SHALL go to 0; out_c and out_tag SHALL hold their values.
REQ-023 Minimum latency: a command accepted at edge k with the FIFO empty and the result register free SHALL present out_valid=1 after edge k+1.
REQ-024 Throughput SHALL be one result per cycle while in_valid=1 and out_ready=1 continuously.
REQ-025 A simultaneous push and pop SHALL leave count unchanged.
REQ-026 A push into an empty FIFO SHALL NOT pop on that same edge; no bypass.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 Results SHALL leave in acceptance order.
REQ-029 out_c and out_tag SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-030 With rst=1 at a rising edge: count=0, both pointers=0, out_valid=0, out_c=0, out_tag=0.
REQ-031 A reset asserted mid-operation SHALL discard all queued and held commands with no output.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-033 Macro SHIFT_ZERO_FLAG_EN, when defined, SHALL add output out_zero (1 bit); out_zero is registered on a pop as (sh_c == 0), is reset to 0, and holds with out_c.
REQ-034 When SHIFT_ZERO_FLAG_EN is undefined, out_zero SHALL be absent, and all other behaviour SHALL be identical.

Verification
Benches instantiate the external barrel shifter on the sh_* ports.
REQ-035 sra: push a=0x80000000, b=4, aluc=00, tag=1, with out_ready=1 -> out_valid one edge after acceptance, out_c=0xF8000000, out_tag=1.
REQ-036 sll/srl: push the sequence (0x00000001, 31, 01), (0x80000000, 31, 10), (0x0000F0F0, 4, 11) back to back -> out_c = 0x80000000, 0x00000001, 0x000F0F00 on consecutive cycles.
REQ-037 Backpressure: out_ready=0, offer 6 commands -> 5 accepted (4 in the FIFO plus 1 held in the result register), in_ready=0, count=4; then out_ready=1 -> 5 results in order, count returns to 0.
REQ-038 Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> no push that cycle, count=3; next cycle the push is accepted.
REQ-039 Reset mid-operation: count=3 and out_valid=1, assert rst for 1 cycle -> out_valid=0, count=0, in_ready=1; no stale result is ever emitted.
REQ-040 With SHIFT_ZERO_FLAG_EN defined: push (0x00000001, 1, 10) -> out_c=0, out_zero=1; push (0x00000003, 1, 10) -> out_c=1, out_zero=0.
